// File: rtl/recip_pkg.sv
// Purpose: shared types and the reciprocal-entry rule for the coefficient sequencer.
// Latency: n/a (types and an elaboration-time helper function only).
// Backpressure: n/a.
// Contents: state_e (IDLE/STREAM/DONE); recip_entry(i, frac_w, data_w) =
//   min(floor(2^frac_w/(i+1)), 2^frac_w-1), masked to data_w bits.
package recip_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Only ever called with constant arguments, so it folds to a table of constants.
  // Entry 0 would be exactly 2^frac_w, which does not fit in frac_w fraction
  // bits; it is clamped to the largest representable value instead.
  function automatic int unsigned recip_entry(input int unsigned i,
                                              input int unsigned frac_w,
                                              input int unsigned data_w);
    longint unsigned one;
    longint unsigned v;
    one = 64'd1 << frac_w;
    v   = one / (64'(i) + 64'd1);
    if (v > one - 64'd1) v = one - 64'd1;
    if (data_w < 32) v = v & ((64'd1 << data_w) - 64'd1);
    return 32'(v);
  endfunction

endpackage

// File: rtl/recip_coef_seq_if.sv
// Purpose: control and coefficient-stream bundle between the sequencer and its consumer.
// Latency: n/a (wires only).
// Backpressure: coef_ready from the consumer stalls the stream; start is ignored while busy.
// Ports: master = sequencer side (drives coef_*, busy, done, range_err);
//        slave  = requester/consumer side (drives start, base_addr, count, coef_ready).
interface recip_coef_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 4
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              coef_valid;
  logic              coef_ready;
  logic [DATA_W-1:0] coef_data;
  logic [ADDR_W-1:0] coef_idx;
  logic              coef_last;
  logic              busy;
  logic              done;
  logic              range_err;

  modport master (
    input  start, base_addr, count, coef_ready,
    output coef_valid, coef_data, coef_idx, coef_last, busy, done, range_err
  );

  modport slave (
    output start, base_addr, count, coef_ready,
    input  coef_valid, coef_data, coef_idx, coef_last, busy, done, range_err
  );
endinterface

// File: rtl/recip_table.sv
// Purpose: constant reciprocal table, index -> fixed-point 1/(idx+1); out-of-range -> 0.
// Latency: combinational.
// Backpressure: none.
// Ports: idx (ADDR_W) in, entry (DATA_W) out.
module recip_table
  import recip_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int DEPTH  = 12,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] idx,
  output logic [DATA_W-1:0] entry
);

  // Compare-and-select over the constant entries; unmatched indices fall
  // through to the zero default.
  always_comb begin
    entry = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (idx == ADDR_W'(k)) entry = DATA_W'(recip_entry(k, FRAC_W, DATA_W));
    end
  end

endmodule

// File: rtl/recip_coef_seq.sv
// Purpose: streams a contiguous run of reciprocal coefficients 1/(i+1) from a constant table.
// Latency: accept at edge t -> first beat valid at t+1; done pulses one cycle after the final transfer.
// Backpressure: coef_ready low holds data/idx/last stable; start is ignored while busy.
// Ports: clk, rst_n (async active-low); bus (recip_coef_seq_if.master):
//   start/base_addr/count in, coef_valid/coef_data/coef_idx/coef_last out, coef_ready in,
//   busy/done/range_err out.
module recip_coef_seq
  import recip_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int DEPTH  = 12,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               rst_n,
  recip_coef_seq_if.master  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [CNT_W-1:0]  rem_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  logic              accept;
  logic              xfer;
  logic              final_xfer;
  logic              trunc;
  logic [CNT_W-1:0]  avail;
  logic [CNT_W-1:0]  eff_len;
  logic [ADDR_W-1:0] tbl_idx;
  logic [DATA_W-1:0] tbl_entry;

  // DONE is not busy, so a new run can be accepted during the done pulse.
  assign accept     = bus.start && (state_q != STREAM);
  assign xfer       = (state_q == STREAM) && bus.coef_ready;
  assign final_xfer = xfer && (rem_q == CNT_W'(1));

  // Clip the run to the end of the table; a base beyond the table gives zero beats.
  always_comb begin
    avail   = '0;
    eff_len = '0;
    if (CNT_W'(bus.base_addr) < CNT_W'(DEPTH)) begin
      avail   = CNT_W'(DEPTH) - CNT_W'(bus.base_addr);
      eff_len = (bus.count < avail) ? bus.count : avail;
    end
  end

  assign trunc = (eff_len < bus.count);

  // The table is addressed by the index the data register will hold next.
  // idx_q+1 is only used while more than one beat remains, so it stays in range.
  assign tbl_idx = accept ? bus.base_addr : (idx_q + ADDR_W'(1));

  recip_table #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_table (
    .idx   (tbl_idx),
    .entry (tbl_entry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) state_d = (eff_len == '0) ? DONE : STREAM;
        else        state_d = IDLE;
      end
      STREAM: begin
        if (final_xfer) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      rem_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      err_q <= trunc;
      if (eff_len != '0) begin
        idx_q  <= bus.base_addr;
        rem_q  <= eff_len;
        data_q <= tbl_entry;
      end
    end else if (xfer && !final_xfer) begin
      idx_q  <= idx_q + ADDR_W'(1);
      rem_q  <= rem_q - CNT_W'(1);
      data_q <= tbl_entry;
    end
  end

  // Outputs decode only registered state; nothing from the inputs reaches them combinationally.
  assign bus.coef_valid = (state_q == STREAM);
  assign bus.busy       = (state_q == STREAM);
  assign bus.done       = (state_q == DONE);
  assign bus.coef_last  = (state_q == STREAM) && (rem_q == CNT_W'(1));
  assign bus.coef_idx   = idx_q;
  assign bus.coef_data  = data_q;
  assign bus.range_err  = err_q;

endmodule

// File: tb/tb_recip_coef_seq.sv
module tb_recip_coef_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  recip_coef_seq_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(4)) ifa ();
  recip_coef_seq_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(5)) ifb ();

  recip_coef_seq #(.DATA_W(16), .FRAC_W(8), .DEPTH(12), .ADDR_W(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  recip_coef_seq #(.DATA_W(16), .FRAC_W(10), .DEPTH(16), .ADDR_W(4), .CNT_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t sb[$];
  int    exp12[12] = '{255, 128, 85, 64, 51, 42, 36, 32, 28, 25, 23, 21};

  // Drives one run on dut_a. Expected beats go into the scoreboard at start and
  // are popped on each transfer. toggle=1 uses the ready pattern 1,0,0,1.
  task automatic do_run(input int b, input int c, input bit toggle, input string nm);
    int    len;
    bit    exp_err;
    int    cyc;
    bit    seen_done;
    bit    prev_stall;
    beat_t cur;
    beat_t prev;
    beat_t e;
    len = (b >= 12) ? 0 : ((c < 12 - b) ? c : 12 - b);
    exp_err = (len < c);
    for (int k = 0; k < len; k++) begin
      e.data = 16'(exp12[b + k]);
      e.idx  = 4'(b + k);
      e.last = (k == len - 1);
      sb.push_back(e);
    end
    @(negedge clk);
    ifa.start = 1'b1; ifa.base_addr = 4'(b); ifa.count = 4'(c); ifa.coef_ready = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    n_checks++;
    if (ifa.coef_valid !== (len > 0)) begin
      n_fail++; $display("FAIL %s first_valid: got %b expected %b", nm, ifa.coef_valid, (len > 0));
    end
    n_checks++;
    if (ifa.range_err !== exp_err) begin
      n_fail++; $display("FAIL %s range_err: got %b expected %b", nm, ifa.range_err, exp_err);
    end
    cyc = 1; seen_done = 0; prev_stall = 0; prev = '0;
    while (!seen_done && cyc < 200) begin
      cur = {ifa.coef_data, ifa.coef_idx, ifa.coef_last};
      if (prev_stall) begin
        n_checks++;
        if (cur !== prev) begin
          n_fail++;
          $display("FAIL %s stall_hold: got data=%0d idx=%0d last=%b expected data=%0d idx=%0d last=%b",
                   nm, cur.data, cur.idx, cur.last, prev.data, prev.idx, prev.last);
        end
      end
      if (ifa.done) begin
        seen_done = 1;
        n_checks++;
        if (ifa.coef_valid !== 1'b0) begin
          n_fail++; $display("FAIL %s valid_in_done: got %b expected 0", nm, ifa.coef_valid);
        end
        if (!toggle) begin
          n_checks++;
          if (cyc !== len + 1) begin
            n_fail++; $display("FAIL %s done_cycle: got t+%0d expected t+%0d", nm, cyc, len + 1);
          end
        end
        n_checks++;
        if (sb.size() != 0) begin
          n_fail++; $display("FAIL %s lost_beats: got %0d left expected 0", nm, sb.size());
        end
      end else if (ifa.coef_valid) begin
        ifa.coef_ready = toggle ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : 1'b1;
        if (ifa.coef_ready) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++; $display("FAIL %s extra_beat: got idx=%0d expected none", nm, cur.idx);
          end else begin
            e = sb.pop_front();
            if (cur !== e) begin
              n_fail++;
              $display("FAIL %s beat: got data=%0d idx=%0d last=%b expected data=%0d idx=%0d last=%b",
                       nm, cur.data, cur.idx, cur.last, e.data, e.idx, e.last);
            end
          end
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev = cur;
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (!seen_done) begin
      n_fail++; $display("FAIL %s timeout: got no done expected done", nm);
    end
    n_checks++;
    if ({ifa.done, ifa.busy, ifa.range_err} !== {1'b0, 1'b0, exp_err}) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b busy=%b err=%b expected 0 0 %b",
               nm, ifa.done, ifa.busy, ifa.range_err, exp_err);
    end
    ifa.coef_ready = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.start = 0; ifa.base_addr = 0; ifa.count = 0; ifa.coef_ready = 1;
    ifb.start = 0; ifb.base_addr = 0; ifb.count = 0; ifb.coef_ready = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ifa.coef_valid, ifa.coef_last, ifa.busy, ifa.done, ifa.range_err, ifa.coef_idx, ifa.coef_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got valid=%b last=%b busy=%b done=%b err=%b idx=%0d data=%0d expected all 0",
               ifa.coef_valid, ifa.coef_last, ifa.busy, ifa.done, ifa.range_err, ifa.coef_idx, ifa.coef_data);
    end
    n_checks++;
    if ({ifb.coef_valid, ifb.busy, ifb.done, ifb.range_err, ifb.coef_idx, ifb.coef_data} !== '0) begin
      n_fail++; $display("FAIL reset_b: got valid=%b data=%0d expected all 0", ifb.coef_valid, ifb.coef_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_and_busy();
    @(negedge clk);
    ifa.start = 1; ifa.base_addr = 4'd7; ifa.count = 4'd1; ifa.coef_ready = 0;
    @(negedge clk);
    // Still busy: this request must be dropped.
    ifa.base_addr = 4'd0; ifa.count = 4'd5;
    n_checks++;
    if ({ifa.coef_valid, ifa.busy, ifa.coef_last, ifa.coef_idx, ifa.coef_data} !== {3'b111, 4'd7, 16'd32}) begin
      n_fail++;
      $display("FAIL single_beat: got valid=%b busy=%b last=%b idx=%0d data=%0d expected 1 1 1 7 32",
               ifa.coef_valid, ifa.busy, ifa.coef_last, ifa.coef_idx, ifa.coef_data);
    end
    @(negedge clk);
    n_checks++;
    if ({ifa.coef_valid, ifa.coef_last, ifa.coef_idx, ifa.coef_data} !== {2'b11, 4'd7, 16'd32}) begin
      n_fail++;
      $display("FAIL start_while_busy: got valid=%b idx=%0d data=%0d expected 1 7 32",
               ifa.coef_valid, ifa.coef_idx, ifa.coef_data);
    end
    ifa.start = 0; ifa.coef_ready = 1;
    @(negedge clk);
    n_checks++;
    if ({ifa.done, ifa.coef_valid} !== 2'b10) begin
      n_fail++; $display("FAIL single_done: got done=%b valid=%b expected 1 0", ifa.done, ifa.coef_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({ifa.done, ifa.busy, ifa.coef_valid, ifa.range_err} !== 4'b0000) begin
      n_fail++; $display("FAIL single_idle: got done=%b busy=%b valid=%b err=%b expected 0 0 0 0",
                         ifa.done, ifa.busy, ifa.coef_valid, ifa.range_err);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ifa.start = 1; ifa.base_addr = 4'd0; ifa.count = 4'd2; ifa.coef_ready = 1;
    @(negedge clk);
    ifa.start = 0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (ifa.done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first_done: got %b expected 1", ifa.done);
    end
    ifa.start = 1; ifa.base_addr = 4'd3; ifa.count = 4'd2;
    @(negedge clk);
    ifa.start = 0;
    n_checks++;
    if ({ifa.coef_valid, ifa.done, ifa.coef_idx, ifa.coef_data} !== {2'b10, 4'd3, 16'd64}) begin
      n_fail++; $display("FAIL b2b_second_start: got valid=%b done=%b idx=%0d data=%0d expected 1 0 3 64",
                         ifa.coef_valid, ifa.done, ifa.coef_idx, ifa.coef_data);
    end
    @(negedge clk);
    n_checks++;
    if ({ifa.coef_last, ifa.coef_idx, ifa.coef_data} !== {1'b1, 4'd4, 16'd51}) begin
      n_fail++; $display("FAIL b2b_second_last: got last=%b idx=%0d data=%0d expected 1 4 51",
                         ifa.coef_last, ifa.coef_idx, ifa.coef_data);
    end
    @(negedge clk);
    n_checks++;
    if (ifa.done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second_done: got %b expected 1", ifa.done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    ifa.start = 1; ifa.base_addr = 4'd0; ifa.count = 4'd12; ifa.coef_ready = 1;
    @(negedge clk);
    ifa.start = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ifa.coef_idx !== 4'd3) begin
      n_fail++; $display("FAIL midrun_pos: got idx=%0d expected 3", ifa.coef_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ifa.coef_valid, ifa.coef_last, ifa.busy, ifa.done, ifa.range_err, ifa.coef_idx, ifa.coef_data} !== '0) begin
      n_fail++; $display("FAIL midrun_reset: got valid=%b busy=%b idx=%0d data=%0d expected all 0",
                         ifa.coef_valid, ifa.busy, ifa.coef_idx, ifa.coef_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ifa.coef_valid, ifa.busy, ifa.done} !== 3'b000) begin
      n_fail++; $display("FAIL post_reset_idle: got valid=%b busy=%b done=%b expected 0 0 0",
                         ifa.coef_valid, ifa.busy, ifa.done);
    end
    do_run(0, 2, 0, "post_reset_run");
  endtask

  task automatic test_params();
    int q[$];
    int cyc;
    int got_done;
    int ev;
    for (int i = 0; i < 16; i++) begin
      ev = 1024 / (i + 1);
      if (ev > 1023) ev = 1023;
      q.push_back(ev);
    end
    @(negedge clk);
    ifb.start = 1; ifb.base_addr = 4'd0; ifb.count = 5'd16; ifb.coef_ready = 1;
    @(negedge clk);
    ifb.start = 0;
    cyc = 1; got_done = 0;
    while (got_done == 0 && cyc < 100) begin
      if (ifb.done) begin
        got_done = cyc;
      end else if (ifb.coef_valid) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL params_extra: got idx=%0d expected none", ifb.coef_idx);
        end else begin
          ev = q.pop_front();
          if ({16'(ifb.coef_data), ifb.coef_idx} !== {16'(ev), 4'(cyc - 1)}) begin
            n_fail++; $display("FAIL params_beat: got data=%0d idx=%0d expected data=%0d idx=%0d",
                               ifb.coef_data, ifb.coef_idx, ev, cyc - 1);
          end
        end
        if (ifb.coef_idx == 4'd0 || ifb.coef_idx == 4'd2 || ifb.coef_idx == 4'd15) begin
          n_checks++;
          ev = (ifb.coef_idx == 4'd0) ? 1023 : ((ifb.coef_idx == 4'd2) ? 341 : 64);
          if (int'(ifb.coef_data) !== ev) begin
            n_fail++; $display("FAIL params_const idx %0d: got %0d expected %0d", ifb.coef_idx, ifb.coef_data, ev);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (got_done !== 17 || q.size() != 0) begin
      n_fail++; $display("FAIL params_done: got done at t+%0d with %0d left expected t+17 with 0", got_done, q.size());
    end
  endtask

  initial begin
    test_reset();
    do_run(0, 12, 0, "full_run");
    do_run(0, 12, 1, "toggle_ready");
    test_single_and_busy();
    do_run(10, 5, 0, "truncate");
    do_run(3, 0, 0, "count_zero");
    do_run(12, 3, 0, "base_oob");
    do_run(11, 1, 1, "last_entry");
    test_back_to_back();
    test_reset_midrun();
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/recip_coef_seq.md
# recip_coef_seq

Parametrised reciprocal-coefficient sequencer for the accelerator datapath. It holds a table of fixed-point reciprocals 1/(i+1) for i = 0..DEPTH-1 and streams a contiguous run of entries to the consuming MAC/series unit over a valid/ready handshake. The address range, entry count, and fractional precision are all set at elaboration. It replaces the fixed 12-entry, 8-bit-fraction combinational lookup; a random single-entry read is a stream of count 1.

## Interface
- DATA_W, 16, coefficient output width (DATA_W ≥ FRAC_W)
- FRAC_W, 8, fractional bits; entry i = min(floor(2^FRAC_W/(i+1)), 2^FRAC_W−1), zero-extended to DATA_W
- DEPTH, 12, number of table entries (≥ 2)
- ADDR_W, $clog2(DEPTH), index width
- CNT_W, $clog2(DEPTH+1), count width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a run; accepted only when busy=0
- base_addr  in  ADDR_W  first index of the run, sampled on accept
- count  in  CNT_W  number of entries requested, sampled on accept
- coef_valid  out  1  coefficient beat available
- coef_ready  in  1  consumer accepts the beat
- coef_data  out  DATA_W  table entry at coef_idx
- coef_idx  out  ADDR_W  index of the current beat
- coef_last  out  1  current beat is the final beat of the run
- busy  out  1  a run is in progress
- done  out  1  one-cycle pulse after the final transfer, or after a count-0 accept
- range_err  out  1  last accepted run was truncated; sticky until the next accept

## Operation
- States: IDLE, STREAM, DONE.
- Accept occurs when start=1 and busy=0. busy=0 holds in IDLE and in DONE. On accept, clear range_err.
- Effective length is L = min(count, DEPTH − base_addr). If base_addr ≥ DEPTH, L = 0. If L < count, set range_err=1.
- IDLE + accept:
  - L=0 → DONE; no beats.
  - L>0 → STREAM with coef_idx=base_addr, beats remaining = L.
- STREAM:
  - coef_valid=1.
  - coef_last=1 when remaining = 1.
  - A transfer happens on an edge with valid&ready. Each non-final transfer increments coef_idx and decrements remaining. The final transfer → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE. An accept in DONE is legal and behaves as an accept from IDLE.
- While coef_valid=1 and coef_ready=0, coef_data, coef_idx and coef_last hold stable.
- start while busy=1 is ignored, with no side effects.
- Arithmetic:
  - Table values are computed at elaboration; there is no runtime divider.
  - The saturation rule clamps entry 0 to 2^FRAC_W−1.
  - Index arithmetic never wraps past DEPTH−1.
- Reset (any time, including mid-run): state=IDLE. coef_valid, coef_last, busy, done, range_err = 0. coef_idx=0, coef_data=0. A partial run is discarded.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Accept at edge t → coef_valid=1 from t+1 with entry base_addr.
- With ready held high, one beat transfers per cycle, with no bubbles. L beats occupy cycles t+1..t+L; done pulses at t+L+1.
- Count-0 or out-of-range accept at t → done=1 in cycle t+1, coef_valid stays 0.
- Back-to-back: a start accepted during the DONE cycle makes the first beat valid in the next cycle. Minimum gap between runs is one cycle (DONE).
- Reset assertion clears outputs asynchronously. Release is synchronous to clk.

## Structure
- Shared package recip_pkg contains:
  - state enum {IDLE, STREAM, DONE};
  - function recip_entry(i, FRAC_W, DATA_W) implementing the saturating floor rule.
- Sub-module recip_table: purely combinational, parametrised (DATA_W, FRAC_W, DEPTH). It maps index → entry via recip_entry; out-of-range indices return 0.
- recip_coef_seq instantiates recip_table and registers its output alongside the FSM, index counter and remaining-beat counter.

## Test plan
- Reset, then base=0, count=12, ready=1 → data 255,128,85,64,51,42,36,32,28,25,23,21 on consecutive cycles; coef_last on the 12th beat; done at the cycle after; range_err=0.
- Same run, ready toggling 1,0,0,1 repeatedly → identical sequence, no beat lost or duplicated; data/idx stable through every stall.
- base=7, count=1 → single beat 32, idx 7, coef_last=1; done next cycle. A start during busy is ignored.
- Truncation and zero-length cases:
  - base=10, count=5 → beats 23, 21, with last on 21; range_err=1 until the next accept.
  - count=0 → done at t+1, no valid.
  - base=12 → done at t+1, range_err=1.
- rst_n pulsed low on the 4th beat of a 12-beat run → outputs zero immediately. After release, a new base=0, count=2 run yields 255, 128.
- Parameters FRAC_W=10, DEPTH=16 → entry 0 = 1023, entry 2 = 341, entry 15 = 64. A full 16-beat stream is correct.
